// File: rtl/sample_counter_pkg.sv
// counter_pkg: constants shared by the sample counting datapath.
//   SAMPLE_CNT_BITS   - width of the sample count register
//   SAMPLES_PER_BATCH - number of accepted samples that close out one batch
package counter_pkg;

  localparam int SAMPLE_CNT_BITS   = 10;
  localparam int SAMPLES_PER_BATCH = 1000;

endpackage : counter_pkg

// File: rtl/sample_counter_if.sv
// sample_counter_if: controller <-> sample counter signal bundle.
//   cnt_up        - one pulse per accepted sample (controller drives)
//   clear         - synchronous clear of count and batch flag (controller drives)
//   one_k_samples - registered level, high while the count sits at the batch size
//   sample_count  - registered running count, exported for monitoring only
// Modports:
//   master - controller side
//   slave  - counter side
interface sample_counter_if
  import counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = SAMPLE_CNT_BITS
);

  logic                    cnt_up;
  logic                    clear;
  logic                    one_k_samples;
  logic [NUM_CNT_BITS-1:0] sample_count;

  modport master (
    output cnt_up,
    output clear,
    input  one_k_samples,
    input  sample_count
  );

  modport slave (
    input  cnt_up,
    input  clear,
    output one_k_samples,
    output sample_count
  );

endinterface : sample_counter_if

// File: rtl/sample_counter_flex_counter.sv
// flex_counter: generic rollover counter.
// Counts enabled edges 1..rollover_val and wraps back to 1, raising a registered
// level flag while the count equals rollover_val.
// Ports:
//   clk           - rising-edge clock
//   n_rst         - synchronous reset, ACTIVE-HIGH despite the name
//   clear         - synchronous clear of count and flag, beats count_enable
//   count_enable  - advance the count by one on this edge
//   rollover_val  - terminal count, must be non-zero
//   count_out     - registered count
//   rollover_flag - registered flag, high while count_out == rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;
  // One extra bit so the increment compare never aliases through 2^N.
  logic [NUM_CNT_BITS:0]   count_plus;
  logic [NUM_CNT_BITS:0]   rollover_ext;

  assign count_plus   = {1'b0, count_out} + {{NUM_CNT_BITS{1'b0}}, 1'b1};
  assign rollover_ext = {1'b0, rollover_val};

  // Next-state logic: clear > enable > hold. Wrapping goes to 1, not 0, so a
  // continuously enabled counter cycles through exactly rollover_val states.
  always_comb begin
    next_count = count_out;
    next_flag  = rollover_flag;
    if (clear) begin
      next_count = '0;
      next_flag  = 1'b0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
        next_flag  = (rollover_val == {{(NUM_CNT_BITS-1){1'b0}}, 1'b1});
      end else begin
        next_count = count_plus[NUM_CNT_BITS-1:0];
        next_flag  = (count_plus == rollover_ext);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule : flex_counter

// File: rtl/sample_counter.sv
// sample_counter: counts accepted sample strobes and flags each completed batch.
// Ports:
//   clk   - rising-edge clock
//   n_rst - synchronous reset, ACTIVE-HIGH despite the name
//   bus   - slave side of sample_counter_if (cnt_up, clear in;
//           one_k_samples, sample_count out)
// Parameters:
//   NUM_CNT_BITS - count width, 2^NUM_CNT_BITS must exceed ROLLOVER_VAL
//   ROLLOVER_VAL - samples per batch, 1 .. 2^NUM_CNT_BITS-1
module sample_counter
  import counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = SAMPLE_CNT_BITS,
  parameter int ROLLOVER_VAL = SAMPLES_PER_BATCH
) (
  input  logic             clk,
  input  logic             n_rst,
  sample_counter_if.slave  bus
);

  localparam logic [NUM_CNT_BITS-1:0] ROLLOVER_CONST = NUM_CNT_BITS'(ROLLOVER_VAL);

  logic [NUM_CNT_BITS-1:0] count;
  logic                    flag;

  flex_counter #(
    .NUM_CNT_BITS (NUM_CNT_BITS)
  ) u_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (bus.clear),
    .count_enable  (bus.cnt_up),
    .rollover_val  (ROLLOVER_CONST),
    .count_out     (count),
    .rollover_flag (flag)
  );

  assign bus.one_k_samples = flag;
  assign bus.sample_count  = count;

endmodule : sample_counter

// File: tb/tb_sample_counter.sv
// tb_sample_counter: directed self-checking bench for sample_counter with the
// default batch size of 1000. Inputs change on the falling edge, outputs are
// sampled on the falling edge after each rising edge.
module tb_sample_counter;

  logic clk;
  logic n_rst;
  int   compared;
  int   mismatched;

  sample_counter_if #(.NUM_CNT_BITS(10)) bus ();

  sample_counter #(
    .NUM_CNT_BITS (10),
    .ROLLOVER_VAL (1000)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_flag(input string name, input logic expected);
    compared++;
    if (bus.one_k_samples !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: one_k_samples=%b expected=%b", name, bus.one_k_samples, expected);
    end
  endtask

  task automatic check_count(input string name, input int expected);
    compared++;
    if (bus.sample_count !== 10'(expected)) begin
      mismatched++;
      $display("[TB] FAIL %s: count=%0d expected=%0d", name, bus.sample_count, expected);
    end
  endtask

  task automatic do_reset();
    n_rst      = 1'b1;
    bus.cnt_up = 1'b0;
    bus.clear  = 1'b0;
    step();
    n_rst = 1'b0;
  endtask

  task automatic enable_n(input int n);
    bus.cnt_up = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.cnt_up = 1'b0;
  endtask

  task automatic test_reset();
    n_rst      = 1'b1;
    bus.cnt_up = 1'b1;
    bus.clear  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_flag("reset_flag", 1'b0);
      check_count("reset_count", 0);
    end
    n_rst      = 1'b0;
    bus.cnt_up = 1'b0;
  endtask

  task automatic test_continuous();
    do_reset();
    bus.cnt_up = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      step();
      check_flag("continuous_flag", (k == 1000) || (k == 2000));
      if (k == 999)  check_count("continuous_999", 999);
      if (k == 1000) check_count("continuous_1000", 1000);
      if (k == 1001) check_count("continuous_rollover", 1);
      if (k == 2000) check_count("continuous_2000", 1000);
    end
    bus.cnt_up = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    enable_n(1000);
    check_flag("hold_reach", 1'b1);
    for (int i = 0; i < 50; i++) begin
      step();
      check_flag("hold_level", 1'b1);
    end
    check_count("hold_count", 1000);
    enable_n(1);
    check_flag("hold_release_flag", 1'b0);
    check_count("hold_release_count", 1);
  endtask

  task automatic test_clear();
    do_reset();
    enable_n(100);
    check_count("clear_pre", 100);
    bus.clear = 1'b1;
    step();
    check_count("clear_first", 0);
    step();
    bus.clear = 1'b0;
    check_count("clear_second", 0);
    check_flag("clear_flag", 1'b0);
    enable_n(999);
    check_flag("clear_999", 1'b0);
    check_count("clear_999_count", 999);
    enable_n(1);
    check_flag("clear_1000", 1'b1);
  endtask

  task automatic test_priority();
    do_reset();
    enable_n(1000);
    check_flag("prio_at_1000", 1'b1);
    bus.clear  = 1'b1;
    bus.cnt_up = 1'b1;
    step();
    bus.clear  = 1'b0;
    bus.cnt_up = 1'b0;
    check_flag("prio_clear_flag", 1'b0);
    check_count("prio_clear_count", 0);
    enable_n(500);
    check_count("prio_mid", 500);
    n_rst      = 1'b1;
    bus.clear  = 1'b1;
    bus.cnt_up = 1'b1;
    step();
    n_rst      = 1'b0;
    bus.clear  = 1'b0;
    bus.cnt_up = 1'b0;
    check_count("prio_reset_count", 0);
    check_flag("prio_reset_flag", 1'b0);
    enable_n(1);
    check_count("prio_resume", 1);
  endtask

  task automatic test_gapped();
    do_reset();
    for (int k = 1; k <= 2000; k++) begin
      bus.cnt_up = (k % 2 == 1);
      step();
      check_flag("gapped_flag", ((k + 1) / 2) == 1000);
    end
    bus.cnt_up = 1'b0;
    check_count("gapped_count", 1000);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    n_rst      = 1'b1;
    bus.cnt_up = 1'b0;
    bus.clear  = 1'b0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_hold();
    test_clear();
    test_priority();
    test_gapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sample_counter
